// File: rtl/draw_text_windows_if.sv
// VGA stream bundle: timing counters, sync/blank flags and 12-bit colour.
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_text_windows.sv
// Multi-window character overlay: menu with cursor navigation plus text pages,
// window switches applied at frame start, three-clock render pipeline.
module draw_text_windows #(
   parameter int                        NUM_WIN   = 4,
   parameter int                        IDX_W     = 3,
   parameter int                        COL_W     = 6,
   parameter int                        ROW_W     = 3,
   parameter logic [NUM_WIN*11-1:0]     WIN_X     = {11'd100, 11'd0, 11'd64, 11'd200},
   parameter logic [NUM_WIN*11-1:0]     WIN_Y     = {11'd300, 11'd0, 11'd64, 11'd100},
   parameter logic [NUM_WIN*8-1:0]      WIN_COLS  = {8'd20, 8'd40, 8'd32, 8'd16},
   parameter logic [NUM_WIN*8-1:0]      WIN_ROWS  = {8'd6, 8'd4, 8'd8, 8'd4},
   parameter logic [NUM_WIN*2-1:0]      WIN_SCALE = {2'd2, 2'd1, 2'd0, 2'd1},
   parameter logic [11:0]               FG_COLOR  = 12'hFFF,
   parameter logic [11:0]               BG_COLOR  = 12'h000,
   parameter logic [3:0]                KEY_UP    = 4'h1,
   parameter logic [3:0]                KEY_DOWN  = 4'h2,
   parameter logic [3:0]                KEY_ENTER = 4'h3,
   parameter logic [3:0]                KEY_ESC   = 4'h4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [3:0]               key,
   vga_if.in                        in,
   vga_if.out                       out,
   input  logic [7:0]               char_line_pixels,
   output logic [ROW_W+COL_W-1:0]   char_xy,
   output logic [3:0]               char_line,
   output logic [IDX_W-1:0]         win_sel,
   output logic [IDX_W-1:0]         menu_cursor
);

   typedef enum logic {MENU, PAGE} state_t;

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic [11:0] rgb;
   } vga_t;

   localparam logic [IDX_W-1:0] FIRST = IDX_W'(1);
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_WIN - 1);

   state_t             state_q;
   logic [3:0]         key_prev_q;
   logic [IDX_W-1:0]   cursor_q;
   logic [IDX_W-1:0]   pending_q;
   logic [IDX_W-1:0]   win_sel_q;
   logic               key_evt;
   logic               frame_start;

   assign key_evt     = (key != 4'h0) && (key != key_prev_q);
   assign frame_start = (in.hcount == 11'd0) && (in.vcount == 11'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= MENU;
         key_prev_q <= 4'h0;
         cursor_q   <= FIRST;
         pending_q  <= '0;
         win_sel_q  <= '0;
      end else begin
         key_prev_q <= key;
         // pending is sampled before this cycle's key event lands
         if (frame_start) win_sel_q <= pending_q;
         if (key_evt) begin
            case (state_q)
               MENU: begin
                  if (key == KEY_UP)
                     cursor_q <= (cursor_q == FIRST) ? LAST : cursor_q - FIRST;
                  else if (key == KEY_DOWN)
                     cursor_q <= (cursor_q == LAST) ? FIRST : cursor_q + FIRST;
                  else if (key == KEY_ENTER) begin
                     pending_q <= cursor_q;
                     state_q   <= PAGE;
                  end
               end
               PAGE: begin
                  if (key == KEY_ESC) begin
                     pending_q <= '0;
                     state_q   <= MENU;
                  end
               end
               default: state_q <= MENU;
            endcase
         end
      end
   end

   assign win_sel     = win_sel_q;
   assign menu_cursor = cursor_q;

   logic [10:0]       wx, wy, dx, dy;
   logic [7:0]        wcols, wrows;
   logic [1:0]        ws;
   logic [15:0]       x_end, y_end;
   logic              in_win;
   logic [COL_W-1:0]  col_c;
   logic [ROW_W-1:0]  row_c;
   logic [3:0]        line_c;
   logic [2:0]        bit_c;
   logic              hl_c;
   int                widx;

   always_comb begin
      widx   = int'(win_sel_q);
      wx     = WIN_X[widx*11 +: 11];
      wy     = WIN_Y[widx*11 +: 11];
      wcols  = WIN_COLS[widx*8 +: 8];
      wrows  = WIN_ROWS[widx*8 +: 8];
      ws     = WIN_SCALE[widx*2 +: 2];
      dx     = in.hcount - wx;
      dy     = in.vcount - wy;
      x_end  = 16'(wx) + (16'(wcols) << (int'(ws) + 3));
      y_end  = 16'(wy) + (16'(wrows) << (int'(ws) + 4));
      in_win = (in.hcount >= wx) && (16'(in.hcount) < x_end) &&
               (in.vcount >= wy) && (16'(in.vcount) < y_end);
      col_c  = COL_W'(dx >> (int'(ws) + 3));
      row_c  = ROW_W'(dy >> (int'(ws) + 4));
      line_c = 4'(dy >> ws);
      bit_c  = ~3'(dx >> ws);
      hl_c   = (win_sel_q == '0) && (int'(row_c) == int'(cursor_q) - 1);
   end

   logic [ROW_W+COL_W-1:0] char_xy_q;
   logic [3:0]             char_line_q;
   logic                   in_win_p1_q, in_win_p2_q;
   logic [2:0]             bit_p1_q, bit_p2_q;
   logic                   hl_p1_q, hl_p2_q;
   vga_t                   vga_p1_q, vga_p2_q;
   logic                   px;
   logic [11:0]            glyph_rgb;

   always_comb begin
      px        = char_line_pixels[bit_p2_q];
      glyph_rgb = (px ^ hl_p2_q) ? FG_COLOR : BG_COLOR;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         char_xy_q   <= '0;
         char_line_q <= '0;
         in_win_p1_q <= 1'b0;
         bit_p1_q    <= '0;
         hl_p1_q     <= 1'b0;
         vga_p1_q    <= '0;
         in_win_p2_q <= 1'b0;
         bit_p2_q    <= '0;
         hl_p2_q     <= 1'b0;
         vga_p2_q    <= '0;
         out.hcount  <= '0;
         out.vcount  <= '0;
         out.hsync   <= 1'b0;
         out.vsync   <= 1'b0;
         out.hblnk   <= 1'b0;
         out.vblnk   <= 1'b0;
         out.rgb     <= '0;
      end else begin
         // stage 1: window geometry and ROM address
         char_xy_q   <= in_win ? {row_c, col_c} : '0;
         char_line_q <= in_win ? line_c : '0;
         in_win_p1_q <= in_win;
         bit_p1_q    <= bit_c;
         hl_p1_q     <= hl_c;
         vga_p1_q    <= {in.hcount, in.vcount, in.hsync, in.vsync, in.hblnk, in.vblnk, in.rgb};
         // stage 2: wait for ROM glyph row
         in_win_p2_q <= in_win_p1_q;
         bit_p2_q    <= bit_p1_q;
         hl_p2_q     <= hl_p1_q;
         vga_p2_q    <= vga_p1_q;
         // stage 3: pixel colour
         out.hcount  <= vga_p2_q.hcount;
         out.vcount  <= vga_p2_q.vcount;
         out.hsync   <= vga_p2_q.hsync;
         out.vsync   <= vga_p2_q.vsync;
         out.hblnk   <= vga_p2_q.hblnk;
         out.vblnk   <= vga_p2_q.vblnk;
         out.rgb     <= in_win_p2_q ? glyph_rgb : vga_p2_q.rgb;
      end
   end

   assign char_xy   = char_xy_q;
   assign char_line = char_line_q;

endmodule

// File: tb/tb_draw_text_windows.sv
// Directed bench for draw_text_windows with a scoreboard of expected results.
module tb_draw_text_windows;
   localparam int NUM_WIN = 4;
   localparam int IDX_W   = 3;
   localparam int COL_W   = 6;
   localparam int ROW_W   = 3;
   localparam logic [11:0] FG = 12'hFFF;
   localparam logic [11:0] BG = 12'h000;
   localparam logic [3:0] K_UP = 4'h1, K_DOWN = 4'h2, K_ENTER = 4'h3, K_ESC = 4'h4;

   // model geometry, window 0 first
   int WX[4] = '{200, 64, 0, 100};
   int WY[4] = '{100, 64, 0, 300};
   int WC[4] = '{16, 32, 40, 20};
   int WR[4] = '{4, 8, 4, 6};
   int WS[4] = '{1, 0, 1, 2};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [3:0] key = 4'h0;
   logic [7:0] glyph = 8'h00;
   logic [ROW_W+COL_W-1:0] char_xy;
   logic [3:0] char_line;
   logic [IDX_W-1:0] win_sel;
   logic [IDX_W-1:0] menu_cursor;

   vga_if vin ();
   vga_if vout ();

   always #5 clk = ~clk;

   draw_text_windows #(
      .NUM_WIN(NUM_WIN), .IDX_W(IDX_W), .COL_W(COL_W), .ROW_W(ROW_W),
      .WIN_X({11'd100, 11'd0, 11'd64, 11'd200}),
      .WIN_Y({11'd300, 11'd0, 11'd64, 11'd100}),
      .WIN_COLS({8'd20, 8'd40, 8'd32, 8'd16}),
      .WIN_ROWS({8'd6, 8'd4, 8'd8, 8'd4}),
      .WIN_SCALE({2'd2, 2'd1, 2'd0, 2'd1}),
      .FG_COLOR(FG), .BG_COLOR(BG),
      .KEY_UP(K_UP), .KEY_DOWN(K_DOWN), .KEY_ENTER(K_ENTER), .KEY_ESC(K_ESC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key(key),
      .in(vin), .out(vout),
      .char_line_pixels(glyph),
      .char_xy(char_xy), .char_line(char_line),
      .win_sel(win_sel), .menu_cursor(menu_cursor)
   );

   typedef struct {
      int          due;
      logic [8:0]  xy;
      logic [3:0]  line;
      logic [2:0]  win;
      logic [2:0]  cur;
   } st1_t;

   typedef struct {
      int          due;
      logic [10:0] h;
      logic [10:0] v;
      logic [3:0]  sb;
      logic [11:0] rgb;
   } st3_t;

   st1_t q1[$];
   st3_t q3[$];
   int   edge_n = 0;
   int   vectors = 0;
   int   miscompares = 0;

   int   m_win = 0, m_cur = 1, m_pend = 0;
   bit   m_page = 1'b0;
   logic [3:0] m_kprev = 4'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   st1_t a_m;
   st3_t b_m;
   always @(posedge clk) begin
      edge_n++;
      #1;
      while (q1.size() > 0 && q1[0].due <= edge_n) begin
         a_m = q1.pop_front();
         chk("char_xy", 32'(char_xy), 32'(a_m.xy));
         chk("char_line", 32'(char_line), 32'(a_m.line));
         chk("win_sel", 32'(win_sel), 32'(a_m.win));
         chk("menu_cursor", 32'(menu_cursor), 32'(a_m.cur));
      end
      while (q3.size() > 0 && q3[0].due <= edge_n) begin
         b_m = q3.pop_front();
         chk("out_hcount", 32'(vout.hcount), 32'(b_m.h));
         chk("out_vcount", 32'(vout.vcount), 32'(b_m.v));
         chk("out_syncblank", 32'({vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}), 32'(b_m.sb));
         chk("out_rgb", 32'(vout.rgb), 32'(b_m.rgb));
      end
   end

   // drive one pixel at a negedge and predict its results
   task automatic step(input int h, input int v);
      st1_t a;
      st3_t b;
      int x, y, s, w, col, row, old_pend;
      bit ins, px, hl;
      logic [11:0] rin;
      logic [3:0] sb;
      rin = 12'($urandom);
      sb  = 4'($urandom);
      vin.hcount = 11'(h);
      vin.vcount = 11'(v);
      {vin.hsync, vin.vsync, vin.hblnk, vin.vblnk} = sb;
      vin.rgb = rin;
      w = m_win;
      s = WS[w];
      x = h - WX[w];
      y = v - WY[w];
      ins = (x >= 0) && (x < WC[w] * 8 * (1 << s)) && (y >= 0) && (y < WR[w] * 16 * (1 << s));
      a.xy = 9'd0;
      a.line = 4'd0;
      b.rgb = rin;
      if (ins) begin
         col = x / (8 << s);
         row = y / (16 << s);
         a.xy = {row[2:0], col[5:0]};
         a.line = 4'((y >> s) % 16);
         hl = (w == 0) && (row == m_cur - 1);
         px = glyph[7 - ((x >> s) % 8)];
         if (hl) b.rgb = px ? BG : FG;
         else    b.rgb = px ? FG : BG;
      end
      old_pend = m_pend;
      if (key != 4'h0 && key != m_kprev) begin
         if (!m_page) begin
            if (key == K_UP)         m_cur = (m_cur == 1) ? NUM_WIN - 1 : m_cur - 1;
            else if (key == K_DOWN)  m_cur = (m_cur == NUM_WIN - 1) ? 1 : m_cur + 1;
            else if (key == K_ENTER) begin m_pend = m_cur; m_page = 1'b1; end
         end else if (key == K_ESC) begin
            m_pend = 0;
            m_page = 1'b0;
         end
      end
      m_kprev = key;
      if (h == 0 && v == 0) m_win = old_pend;
      a.win = 3'(m_win);
      a.cur = 3'(m_cur);
      a.due = edge_n + 1;
      b.h = 11'(h);
      b.v = 11'(v);
      b.sb = sb;
      b.due = edge_n + 3;
      q1.push_back(a);
      q3.push_back(b);
      @(negedge clk);
   endtask

   task automatic press(input logic [3:0] k);
      key = k;
      step(800, 700);
      step(800, 700);
      key = 4'h0;
      step(800, 700);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q1.size() + q3.size()) > 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", 32'(q1.size() + q3.size()), 32'd0);
      q1.delete();
      q3.delete();
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_hcount"}, 32'(vout.hcount), 32'd0);
      chk({tag, "_vcount"}, 32'(vout.vcount), 32'd0);
      chk({tag, "_sb"}, 32'({vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}), 32'd0);
      chk({tag, "_rgb"}, 32'(vout.rgb), 32'd0);
      chk({tag, "_char_xy"}, 32'(char_xy), 32'd0);
      chk({tag, "_char_line"}, 32'(char_line), 32'd0);
      chk({tag, "_win_sel"}, 32'(win_sel), 32'd0);
      chk({tag, "_cursor"}, 32'(menu_cursor), 32'd1);
   endtask

   task automatic model_reset();
      m_win = 0; m_cur = 1; m_pend = 0; m_page = 1'b0; m_kprev = 4'h0;
   endtask

   initial begin
      vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
      vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;
      repeat (3) @(negedge clk);
      reset_checks("por");
      rst_n = 1'b1;
      @(negedge clk);

      // window 0 edges and a run across char boundaries, cursor on row 0
      glyph = 8'hA5;
      foreach (WY[i]) begin end
      for (int vi = 0; vi < 6; vi++) begin
         int vv;
         case (vi)
            0: vv = 99;  1: vv = 100; 2: vv = 131;
            3: vv = 132; 4: vv = 227; default: vv = 228;
         endcase
         step(199, vv); step(200, vv); step(201, vv); step(207, vv);
         step(208, vv); step(455, vv); step(456, vv);
      end
      for (int h = 196; h <= 236; h++) step(h, 140);
      drain();

      // navigation: held key fires once, wrap both ways, junk codes ignored
      key = K_DOWN;
      repeat (50) step(800, 700);
      key = 4'h0;
      step(800, 700);
      press(K_DOWN);
      press(K_DOWN);
      press(4'h7);
      press(K_ESC);
      press(K_UP);
      press(K_DOWN);
      press(K_DOWN);
      drain();

      // highlighted row 1 with half-lit glyph, row 0 unhighlighted
      glyph = 8'hF0;
      for (int h = 200; h <= 231; h++) step(h, 132);
      for (int h = 200; h <= 215; h++) step(h, 100);
      drain();

      // deferred switch into page 2, then back
      press(K_ENTER);
      step(300, 50);
      step(0, 0);
      for (int h = 0; h <= 5; h++) step(h, 1);
      step(639, 1); step(640, 1); step(10, 127); step(10, 128);
      press(K_UP);
      press(K_ESC);
      step(10, 10);
      step(0, 0);
      step(5, 5);

      // enter and escape within one frame leaves the menu up
      press(K_ENTER);
      press(K_ESC);
      step(0, 0);
      step(5, 5);

      // asynchronous reset mid-line while a page is showing
      press(K_ENTER);
      step(0, 0);
      for (int h = 0; h <= 20; h++) step(h, 5);
      q1.delete();
      q3.delete();
      #2 rst_n = 1'b0;
      #1 reset_checks("midrst");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // post-reset frame renders the menu and passes timing through
      glyph = 8'h3C;
      for (int v = 0; v < 240; v += 8)
         for (int h = 0; h < 480; h++) step(h, v);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation still running, required finish");
      $fatal(1, "timeout");
   end
endmodule
